sha256_compress: RTL and testbench
==================================

Name: sha256_compress

Overview:
Iterative SHA-256 compression engine. It sits directly downstream of message_scheduler.
- Consumes the 64 expanded schedule words W[0..63] plus a 256-bit chaining value H_in.
- Performs the 64 compression rounds, one round per clock.
- Produces the updated chaining value H_out = H_in + final working variables.
- A valid/ready handshake on both sides allows multi-block messages to be chained by the upstream controller.

Parameters:
- ROUNDS, 64, number of compression rounds; fixed by FIPS 180-4 and not intended to be overridden.
- WORD_W, 32, word width in bits.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  W_in and H_in hold a valid block.
- in_ready  output  1  engine can accept a block.
- W_in  input  2048  expanded schedule in message_scheduler.out packing: W[0] in bits 2047:2016, W[63] in bits 31:0.
- H_in  input  256  chaining value; H0 in bits 255:224 through H7 in bits 31:0.
- out_valid  output  1  H_out holds a completed digest state.
- out_ready  input  1  consumer accepts H_out.
- H_out  output  256  updated chaining value, same packing as H_in.

Behaviour:
- Reset, synchronous and active-high, applies in any state including mid-run:
  - state goes to IDLE; round counter = 0; working registers a..h = 0.
  - H_out = 0; out_valid = 0.
  - in_ready = 0 while rst is high.
- FSM states: IDLE, RUN, FINAL, DONE.
- in_ready = 1 only in IDLE with rst low. It is a combinational decode of the state.
- IDLE:
  - On in_valid && in_ready, register W_in into a 64x32 word store and H_in into a 256-bit register.
  - Load a..h = H0..H7; round = 0; go to RUN.
- RUN (one round per cycle, using W[round] and K[round]):
  - T1 = h + Sigma1(e) + Ch(e,f,g) + K[round] + W[round]
  - T2 = Sigma0(a) + Maj(a,b,c)
  - Sigma0 = ROTR2 ^ ROTR13 ^ ROTR22
  - Sigma1 = ROTR6 ^ ROTR11 ^ ROTR25
  - Ch = (e&f) ^ (~e&g)
  - Maj = (a&b) ^ (a&c) ^ (b&c)
  - Next state: h=g, g=f, f=e, e=d+T1, d=c, c=b, b=a, a=T1+T2.
  - All additions are modulo 2^32; carries are discarded.
  - round increments each cycle. After the edge that executes round 63, go to FINAL.
- FINAL (one cycle): register H_out[i] = H_in[i] + working_var[i] mod 2^32 for i = 0..7. Assert out_valid; go to DONE.
- DONE:
  - out_valid and H_out are held stable until out_ready is seen high.
  - On out_valid && out_ready, clear out_valid and go to IDLE. H_out keeps its value.
- Latency: accept edge E0, rounds on edges E1..E64, final add on E65. out_valid is high in the cycle after E65, i.e. 65 cycles after acceptance. Minimum block-to-block interval is 67 cycles (DONE handshake plus the IDLE accept cycle).
- in_valid while not in IDLE is ignored. The latched W/H must not change; upstream must hold its data until in_ready.
- out_ready while not in DONE has no effect.
- W_in and H_in are sampled only at the accept edge. Changes after acceptance must not affect the result.
- Round counter is 6 bits. Terminate on round == 63; never wrap into a second pass.

Decomposition:
- Shared package sha256_pkg holds:
  - K[0..63] round-constant array.
  - IV H0..H7 (6a09e667 ... 5be0cd19).
  - WORD_W.
  - Sigma0/Sigma1/Ch/Maj functions.
  - FSM state enum.
- These helpers are shared with message_scheduler's rho0/rho1 helpers.
- One natural sub-module: sha256_round. It is purely combinational: a..h, K, W in; next a..h out. The top level keeps the FSM, counter, word store and final adder.

Test Plan:
- Expanded schedule for padded "abc" (W[0]=61626380, W[1..14]=0, W[15]=00000018) via message_scheduler; H_in = IV -> H_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; out_valid exactly 65 cycles after accept.
- Empty message (W[0]=80000000, rest 0); H_in = IV -> H_out = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", second block fed with H_in = first H_out -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Hold out_ready low for 10 cycles after out_valid -> H_out stable, in_ready stays 0; raise out_ready -> out_valid drops next cycle, in_ready = 1.
- Assert rst at round 30, then send "abc" -> out_valid = 0 and H_out = 0 after reset; new result matches the "abc" digest. Toggle W_in and in_valid during RUN -> result unchanged.

Source files
------------

// File: rtl/sha256_pkg.sv
// Purpose: shared SHA-256 constants, types, FSM state codes and round helper functions.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package sha256_pkg;

    localparam int WORD_W = 32;
    localparam int ROUNDS = 64;

    // Index 0 is a/H0 and sits in the most-significant word, so a 256-bit
    // chaining value casts straight onto this type.
    typedef logic [0:7][WORD_W-1:0] work_t;

    // W[0] in the most-significant word, matching the scheduler output packing.
    typedef logic [0:ROUNDS-1][WORD_W-1:0] sched_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FINAL = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam sched_t K_TABLE = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam work_t IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] big_sigma0(input logic [WORD_W-1:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [WORD_W-1:0] big_sigma1(input logic [WORD_W-1:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [WORD_W-1:0] ch(input logic [WORD_W-1:0] e,
                                             input logic [WORD_W-1:0] f,
                                             input logic [WORD_W-1:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [WORD_W-1:0] maj(input logic [WORD_W-1:0] a,
                                              input logic [WORD_W-1:0] b,
                                              input logic [WORD_W-1:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_compress_if.sv
// Purpose: block-in / digest-out handshake bundle for the compression engine.
// Latency: n/a (wires only).
// Backpressure: in_ready gates the block input, out_ready gates the digest output.
interface sha256_compress_if;
    logic           in_valid;
    logic           in_ready;
    logic [2047:0]  W_in;
    logic [255:0]   H_in;
    logic           out_valid;
    logic           out_ready;
    logic [255:0]   H_out;

    // master: upstream controller / consumer side.
    modport master (
        output in_valid, W_in, H_in, out_ready,
        input  in_ready, out_valid, H_out
    );

    // slave: the compression engine.
    modport slave (
        input  in_valid, W_in, H_in, out_ready,
        output in_ready, out_valid, H_out
    );
endinterface

// File: rtl/sha256_round.sv
// Purpose: one SHA-256 compression round; cur a..h, K, W in -> next a..h out.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
module sha256_round
    import sha256_pkg::*;
(
    input  work_t             cur,
    input  logic [WORD_W-1:0] k,
    input  logic [WORD_W-1:0] w,
    output work_t             nxt
);
    logic [WORD_W-1:0] t1;
    logic [WORD_W-1:0] t2;

    always_comb begin
        t1  = cur[7] + big_sigma1(cur[4]) + ch(cur[4], cur[5], cur[6]) + k + w;
        t2  = big_sigma0(cur[0]) + maj(cur[0], cur[1], cur[2]);
        nxt = {t1 + t2, cur[0], cur[1], cur[2], cur[3] + t1, cur[4], cur[5], cur[6]};
    end
endmodule

// File: rtl/sha256_compress.sv
// Purpose: iterative SHA-256 compression, one round per clock; ports clk, rst, bus (in/out handshake).
// Latency: out_valid rises 65 cycles after the accept edge; 67-cycle minimum block interval.
// Backpressure: in_ready only in IDLE; H_out/out_valid held in DONE until out_ready.
module sha256_compress
    import sha256_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    sha256_compress_if.slave    bus
);
    logic [1:0] state_q,     state_d;
    logic [5:0] round_q,     round_d;
    work_t      work_q,      work_d;
    sched_t     w_store_q,   w_store_d;
    work_t      h_in_q,      h_in_d;
    work_t      h_out_q,     h_out_d;
    logic       out_valid_q, out_valid_d;

    logic       in_ready;
    work_t      round_nxt;

    assign in_ready      = (state_q == ST_IDLE) && !rst;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.H_out     = h_out_q;

    sha256_round u_round (
        .cur (work_q),
        .k   (K_TABLE[round_q]),
        .w   (w_store_q[round_q]),
        .nxt (round_nxt)
    );

    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        work_d      = work_q;
        w_store_d   = w_store_q;
        h_in_d      = h_in_q;
        h_out_d     = h_out_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                // The only point where W_in/H_in are sampled.
                if (bus.in_valid && in_ready) begin
                    w_store_d = bus.W_in;
                    h_in_d    = bus.H_in;
                    work_d    = bus.H_in;
                    round_d   = 6'd0;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                work_d  = round_nxt;
                round_d = round_q + 6'd1;
                // Counter wraps to 0 here, but the state change stops a second pass.
                if (round_q == 6'd63) begin
                    state_d = ST_FINAL;
                end
            end
            ST_FINAL: begin
                for (int i = 0; i < 8; i++) begin
                    h_out_d[i] = h_in_q[i] + work_q[i];
                end
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            default: begin
                // H_out keeps its value after the handshake.
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            round_q     <= 6'd0;
            work_q      <= '0;
            w_store_q   <= '0;
            h_in_q      <= '0;
            h_out_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            work_q      <= work_d;
            w_store_q   <= w_store_d;
            h_in_q      <= h_in_d;
            h_out_q     <= h_out_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_sha256_compress.sv
module tb_sha256_compress;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    sha256_compress_if bus();

    sha256_compress dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    localparam logic [255:0] IV_H      = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] ABC_DIG   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] EMPTY_DIG = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] TWO_DIG   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    int unsigned kt [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic int unsigned rr(input int unsigned x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Message schedule expansion of one padded 512-bit block.
    function automatic logic [2047:0] expand(input logic [511:0] blk);
        int unsigned w [64];
        logic [2047:0] r;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = w[t-16] + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3))
                 + w[t-7]  + (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10));
        for (int t = 0; t < 64; t++) r[2047-32*t -: 32] = w[t];
        return r;
    endfunction

    // Reference compression: working variables as an array shifted down each round.
    function automatic logic [255:0] model(input logic [2047:0] wp, input logic [255:0] hp);
        int unsigned v [8];
        int unsigned hh [8];
        int unsigned t1, t2, wt;
        logic [255:0] r;
        for (int i = 0; i < 8; i++) begin
            hh[i] = hp[255-32*i -: 32];
            v[i]  = hh[i];
        end
        for (int t = 0; t < 64; t++) begin
            wt = wp[2047-32*t -: 32];
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + kt[t] + wt;
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hh[i] + v[i];
        return r;
    endfunction

    function automatic logic [2047:0] rand_w();
        logic [2047:0] r;
        for (int i = 0; i < 64; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] rand_h();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Offers a block, waits for acceptance then out_valid (bounded). lat = -1 on timeout.
    task automatic run_block(input logic [2047:0] w, input logic [255:0] h,
                             output logic [255:0] dig, output int lat);
        int budget;
        budget = 0;
        bus.W_in = w;
        bus.H_in = h;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && budget < 200) begin
            @(posedge clk); #1; budget++;
        end
        if (!bus.in_ready) begin
            bus.in_valid = 1'b0;
            lat = -1;
            dig = '0;
        end else begin
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            lat = 0;
            while (!bus.out_valid && lat < 200) begin
                @(posedge clk); #1; lat++;
            end
            if (!bus.out_valid) lat = -1;
            dig = bus.H_out;
        end
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.W_in = '0;
        bus.H_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b want 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
        checks++; if (bus.H_out !== 256'h0) begin errors++; $display("FAIL reset_h_out got %h want 0", bus.H_out); end
        rst = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %0b want 1", bus.in_ready); end
    endtask

    task automatic test_abc();
        logic [2047:0] w;
        logic [255:0] dig;
        int lat;
        w = expand({"abc", 8'h80, 416'h0, 64'd24});
        run_block(w, IV_H, dig, lat);
        checks++; if (lat !== 65) begin errors++; $display("FAIL abc_latency got %0d want 65", lat); end
        checks++; if (dig !== ABC_DIG) begin errors++; $display("FAIL abc_digest got %h want %h", dig, ABC_DIG); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL done_in_ready got %0b want 0", bus.in_ready); end
        handshake();
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL abc_release got out_valid=%0b in_ready=%0b want 0/1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_empty();
        logic [255:0] dig;
        int lat;
        run_block(expand({32'h80000000, 480'h0}), IV_H, dig, lat);
        checks++; if (dig !== EMPTY_DIG) begin errors++; $display("FAIL empty_digest got %h want %h", dig, EMPTY_DIG); end
        handshake();
    endtask

    task automatic test_two_block();
        logic [447:0] msg;
        logic [2047:0] w1, w2;
        logic [255:0] d1, d2;
        int lat;
        msg = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
        w1 = expand({msg, 32'h80000000, 32'h0});
        w2 = expand({480'h0, 32'h000001c0});
        run_block(w1, IV_H, d1, lat);
        handshake();
        checks++; if (d1 !== model(w1, IV_H)) begin errors++; $display("FAIL two_block_first got %h want %h", d1, model(w1, IV_H)); end
        run_block(w2, d1, d2, lat);
        handshake();
        checks++; if (d2 !== TWO_DIG) begin errors++; $display("FAIL two_block_digest got %h want %h", d2, TWO_DIG); end
    endtask

    task automatic test_backpressure();
        logic [2047:0] w;
        logic [255:0] h, dig, exp;
        int lat, bad;
        w = rand_w();
        h = rand_h();
        exp = model(w, h);
        run_block(w, h, dig, lat);
        checks++; if (dig !== exp) begin errors++; $display("FAIL bp_digest got %h want %h", dig, exp); end
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.H_out !== exp || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold got %0d unstable cycles want 0", bad); end
        handshake();
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release got out_valid=%0b in_ready=%0b want 0/1", bus.out_valid, bus.in_ready);
        end
        checks++; if (bus.H_out !== exp) begin errors++; $display("FAIL bp_h_out_kept got %h want %h", bus.H_out, exp); end
    endtask

    task automatic test_reset_midrun();
        logic [2047:0] w;
        logic [255:0] dig;
        int lat, budget;
        w = expand({"abc", 8'h80, 416'h0, 64'd24});
        bus.W_in = w;
        bus.H_in = IV_H;
        bus.in_valid = 1'b1;
        budget = 0;
        while (!bus.in_ready && budget < 200) begin @(posedge clk); #1; budget++; end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %0b want 0", bus.in_ready); end
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.H_out !== 256'h0) begin
            errors++; $display("FAIL midrun_reset got out_valid=%0b H_out=%h want 0/0", bus.out_valid, bus.H_out);
        end
        rst = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %0b want 1", bus.in_ready); end
        run_block(w, IV_H, dig, lat);
        checks++; if (dig !== ABC_DIG || lat !== 65) begin
            errors++; $display("FAIL post_rst_abc got %h lat %0d want %h lat 65", dig, lat, ABC_DIG);
        end
        handshake();
    endtask

    task automatic test_ignore_inputs();
        logic [2047:0] w;
        logic [255:0] h, exp;
        int budget, bad;
        w = rand_w();
        h = rand_h();
        exp = model(w, h);
        bus.W_in = w;
        bus.H_in = h;
        bus.in_valid = 1'b1;
        budget = 0;
        while (!bus.in_ready && budget < 200) begin @(posedge clk); #1; budget++; end
        @(posedge clk); #1;
        bad = 0;
        repeat (40) begin
            bus.in_valid = 1'($urandom);
            bus.W_in = rand_w();
            bus.H_in = rand_h();
            if (bus.in_ready !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL run_in_ready got %0d high cycles want 0", bad); end
        budget = 0;
        while (!bus.out_valid && budget < 200) begin @(posedge clk); #1; budget++; end
        checks++; if (bus.out_valid !== 1'b1 || bus.H_out !== exp) begin
            errors++; $display("FAIL ignore_inputs got %h want %h", bus.H_out, exp);
        end
        handshake();
    endtask

    task automatic test_random();
        logic [2047:0] w;
        logic [255:0] h, dig, exp;
        int lat;
        for (int n = 0; n < 4; n++) begin
            w = rand_w();
            h = rand_h();
            exp = model(w, h);
            run_block(w, h, dig, lat);
            checks++; if (dig !== exp || lat !== 65) begin
                errors++; $display("FAIL random_%0d got %h lat %0d want %h lat 65", n, dig, lat, exp);
            end
            handshake();
        end
    endtask

    task automatic test_back_to_back();
        logic [2047:0] wa, wb;
        logic [255:0] ha, hb, da, db;
        int cnt, budget;
        wa = rand_w(); ha = rand_h();
        wb = rand_w(); hb = rand_h();
        da = '0; db = '0;
        bus.out_ready = 1'b1;
        bus.W_in = wa;
        bus.H_in = ha;
        bus.in_valid = 1'b1;
        budget = 0;
        while (!bus.in_ready && budget < 200) begin @(posedge clk); #1; budget++; end
        @(posedge clk); #1;
        bus.W_in = wb;
        bus.H_in = hb;
        cnt = 0;
        while (!bus.in_ready && cnt < 200) begin
            @(posedge clk); #1; cnt++;
            if (bus.out_valid) da = bus.H_out;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++; if (cnt + 1 != 67) begin errors++; $display("FAIL b2b_interval got %0d want 67", cnt + 1); end
        checks++; if (da !== model(wa, ha)) begin errors++; $display("FAIL b2b_first got %h want %h", da, model(wa, ha)); end
        budget = 0;
        while (!bus.out_valid && budget < 200) begin @(posedge clk); #1; budget++; end
        db = bus.H_out;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++; if (db !== model(wb, hb)) begin errors++; $display("FAIL b2b_second got %h want %h", db, model(wb, hb)); end
    endtask

    initial begin
        test_reset();
        test_abc();
        test_empty();
        test_two_block();
        test_backpressure();
        test_reset_midrun();
        test_ignore_inputs();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
